// File: rtl/seg7_scan_driver.sv
// Basys3 4-digit common-anode scan driver with double-buffered load and blink/dead-time support.
// Latency: an/seg/dp are registered one cycle behind scan state; loads commit at frame boundaries; optional SEG7_BRIGHTNESS_EN.
// Backpressure: ready drops after an accepted load and returns the cycle after the commit.
module seg7_scan_driver #(
   parameter int DIGIT_CYCLES = 100_000,
   parameter int BLANK_CYCLES = 1_000,
   parameter int BLINK_CYCLES = 50_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   output logic        ready,
   input  logic [15:0] digits_in,
   input  logic [3:0]  dp_in,
   input  logic [3:0]  blank_in,
   input  logic [3:0]  blink_in,
`ifdef SEG7_BRIGHTNESS_EN
   input  logic [2:0]  brightness,
`endif
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic        frame_done
);

   localparam int MAX_A = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
   localparam int MAX_P = (MAX_A > BLINK_CYCLES) ? MAX_A : BLINK_CYCLES;
   localparam int CW    = $clog2(MAX_P);
   localparam logic [CW-1:0] ONE      = CW'(1);
   localparam logic [CW-1:0] DIG_LAST = CW'(DIGIT_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
   localparam logic [CW-1:0] BLK_LAST = CW'(BLINK_CYCLES - 1);

   typedef enum logic {S_ON, S_GAP} state_t;

   state_t        state_q, state_d;
   logic [1:0]    idx_q, idx_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] bcnt_q;
   logic          phase_q;
   logic          frame_end;

   logic [15:0]   act_dig_q, sh_dig_q;
   logic [3:0]    act_dp_q, act_blank_q, act_blink_q;
   logic [3:0]    sh_dp_q, sh_blank_q, sh_blink_q;
   logic          pend_q;

   logic [3:0]    an_q, an_d;
   logic [6:0]    seg_q, seg_d;
   logic          dp_q, dp_d;
   logic          in_win;

   function automatic logic [6:0] dec7(input logic [3:0] n);
      case (n)
         4'h0: dec7 = 7'b1000000;
         4'h1: dec7 = 7'b1111001;
         4'h2: dec7 = 7'b0100100;
         4'h3: dec7 = 7'b0110000;
         4'h4: dec7 = 7'b0011001;
         4'h5: dec7 = 7'b0010010;
         4'h6: dec7 = 7'b0000010;
         4'h7: dec7 = 7'b1111000;
         4'h8: dec7 = 7'b0000000;
         4'h9: dec7 = 7'b0010000;
         4'hA: dec7 = 7'b0001000;
         4'hB: dec7 = 7'b0000011;
         4'hC: dec7 = 7'b1000110;
         4'hD: dec7 = 7'b0100001;
         4'hE: dec7 = 7'b0000110;
         default: dec7 = 7'b0001110;
      endcase
   endfunction

   // Scan FSM; frame_end marks the final cycle of the digit-0 slot.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q + ONE;
      frame_end = 1'b0;
      case (state_q)
         S_ON: begin
            if (cnt_q == DIG_LAST) begin
               cnt_d = '0;
               if (BLANK_CYCLES > 0) begin
                  state_d = S_GAP;
               end else begin
                  idx_d     = idx_q - 2'd1;
                  frame_end = (idx_q == 2'd0);
               end
            end
         end
         default: begin
            if (cnt_q == GAP_LAST) begin
               cnt_d     = '0;
               state_d   = S_ON;
               idx_d     = idx_q - 2'd1;
               frame_end = (idx_q == 2'd0);
            end
         end
      endcase
   end

`ifdef SEG7_BRIGHTNESS_EN
   logic [CW:0] lim_q, lim_use;
   int          on_len;
   // Window length is latched at the first ON cycle so mid-window changes do not shorten the digit.
   always_comb begin
      on_len = ((int'(brightness) + 1) * DIGIT_CYCLES) / 8;
      if (on_len < 1) on_len = 1;
      lim_use = (state_q == S_ON && cnt_q == '0) ? (CW+1)'(on_len) : lim_q;
      in_win  = ({1'b0, cnt_q} < lim_use);
   end
   always_ff @(posedge clk) begin
      if (rst) lim_q <= '0;
      else     lim_q <= lim_use;
   end
`else
   assign in_win = 1'b1;
`endif

   always_comb begin
      logic vis;
      an_d  = 4'hF;
      seg_d = 7'h7F;
      dp_d  = 1'b1;
      vis   = (state_q == S_ON) &&
              !(act_blank_q[idx_q] | (act_blink_q[idx_q] & phase_q));
      if (vis) begin
         seg_d = dec7(act_dig_q[{idx_q, 2'b00} +: 4]);
         dp_d  = ~act_dp_q[idx_q];
         if (in_win) an_d = ~(4'b0001 << idx_q);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_ON;
         idx_q       <= 2'd3;
         cnt_q       <= '0;
         bcnt_q      <= '0;
         phase_q     <= 1'b0;
         act_dig_q   <= '0;
         act_dp_q    <= '0;
         act_blank_q <= 4'hF;
         act_blink_q <= '0;
         sh_dig_q    <= '0;
         sh_dp_q     <= '0;
         sh_blank_q  <= '0;
         sh_blink_q  <= '0;
         pend_q      <= 1'b0;
         an_q        <= 4'hF;
         seg_q       <= 7'h7F;
         dp_q        <= 1'b1;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         an_q    <= an_d;
         seg_q   <= seg_d;
         dp_q    <= dp_d;
         if (bcnt_q == BLK_LAST) begin
            bcnt_q  <= '0;
            phase_q <= ~phase_q;
         end else begin
            bcnt_q  <= bcnt_q + ONE;
         end
         // Commit sees the pre-accept pending flag, so a same-cycle load waits a frame.
         if (frame_end && pend_q) begin
            act_dig_q   <= sh_dig_q;
            act_dp_q    <= sh_dp_q;
            act_blank_q <= sh_blank_q;
            act_blink_q <= sh_blink_q;
            pend_q      <= 1'b0;
         end
         if (load && !pend_q) begin
            sh_dig_q   <= digits_in;
            sh_dp_q    <= dp_in;
            sh_blank_q <= blank_in;
            sh_blink_q <= blink_in;
            pend_q     <= 1'b1;
         end
      end
   end

   assign ready      = ~pend_q;
   assign frame_done = frame_end;
   assign an         = an_q;
   assign seg        = seg_q;
   assign dp         = dp_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: frame-position reference model checked every cycle, plus table vectors and handshake sequences.
module tb_seg7_scan_driver;
   localparam int DC = 8;
   localparam int BC = 2;
   localparam int KC = 64;
   localparam int SL = DC + BC;
   localparam int FR = 4 * SL;

   logic        clk, rst, load, ready, dp, frame_done;
   logic [15:0] digits_in;
   logic [3:0]  dp_in, blank_in, blink_in, an;
   logic [6:0]  seg;
`ifdef SEG7_BRIGHTNESS_EN
   logic [2:0]  brightness;
   initial brightness = 3'd7;
`endif

   seg7_scan_driver #(.DIGIT_CYCLES(DC), .BLANK_CYCLES(BC), .BLINK_CYCLES(KC)) dut (
      .clk(clk), .rst(rst), .load(load), .ready(ready),
      .digits_in(digits_in), .dp_in(dp_in), .blank_in(blank_in), .blink_in(blink_in),
`ifdef SEG7_BRIGHTNESS_EN
      .brightness(brightness),
`endif
      .an(an), .seg(seg), .dp(dp), .frame_done(frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] dig;
      logic [3:0]  dpv;
      logic [3:0]  bnk;
      logic [3:0]  bkl;
   } buf_t;

   typedef struct {
      buf_t        v;
      logic [15:0] ean;
      logic [27:0] eseg;
      logic [3:0]  edp;
   } vec_t;

   logic [6:0] DEC [16];
   vec_t       tbl [5];

   buf_t       m_act, m_sh;
   bit         m_pend, m_valid;
   int         m_t;
   logic [3:0] e_an;
   logic [6:0] e_seg;
   logic       e_dp;
   logic       obs_fd;
   int         n_cmp = 0;
   int         n_bad = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h (frame pos %0d)", name, got, want, m_t % FR);
      end
   endtask

   // Expected registered outputs for a scan cycle, derived from the frame position alone.
   task automatic model_out(input int t, output logic [3:0] a, output logic [6:0] s, output logic d);
      int pos, slot, w, idx;
      bit ph;
      pos  = t % FR;
      slot = pos / SL;
      w    = pos % SL;
      idx  = 3 - slot;
      ph   = ((t / KC) % 2) == 1;
      a = 4'hF; s = 7'h7F; d = 1'b1;
      if (w < DC && !m_act.bnk[idx] && !(m_act.bkl[idx] && ph)) begin
         a[idx] = 1'b0;
         s = DEC[m_act.dig[idx*4 +: 4]];
         d = ~m_act.dpv[idx];
      end
   endtask

   task automatic step(input logic ld, input buf_t v, input logic r);
      bit acc;
      @(negedge clk);
      if (m_valid) begin
         chk("an", an, e_an);
         chk("seg", seg, e_seg);
         chk("dp", dp, e_dp);
         chk("ready", ready, !m_pend);
         chk("frame_done", frame_done, (m_t % FR) == FR - 1);
      end
      obs_fd    = frame_done;
      load      = ld;
      digits_in = v.dig;
      dp_in     = v.dpv;
      blank_in  = v.bnk;
      blink_in  = v.bkl;
      rst       = r;
      if (r) begin
         m_valid = 1; m_t = 0; m_pend = 0; m_sh = '0;
         m_act = '0; m_act.bnk = 4'hF;
         e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
      end else begin
         model_out(m_t, e_an, e_seg, e_dp);
         acc = ld && !m_pend;
         if ((m_t % FR) == FR - 1 && m_pend) begin
            m_act = m_sh; m_pend = 0;
         end
         if (acc) begin
            m_sh = v; m_pend = 1;
         end
         m_t++;
      end
   endtask

   task automatic wait_fd(input string name);
      int n;
      n = 0; obs_fd = 0;
      while (n < 3 * FR) begin
         step(0, '0, 0);
         n++;
         if (obs_fd) break;
      end
      if (!obs_fd) chk(name, 0, 1);
   endtask

   task automatic apply_vec(input vec_t x);
      int n, s;
      n = 0;
      while (m_pend && n < 3 * FR) begin step(0, '0, 0); n++; end
      step(1, x.v, 0);
      wait_fd("vec_fd_timeout");
      for (int k = 1; k <= FR; k++) begin
         step(0, '0, 0);
         if (k % SL == 5) begin
            s = k / SL;
            chk("vec_an", an, x.ean[15-4*s -: 4]);
            chk("vec_seg", seg, x.eseg[27-7*s -: 7]);
            chk("vec_dp", dp, x.edp[3-s]);
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   n, fdc;
      buf_t rv;
      DEC = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
      tbl[0] = '{'{16'h12AF, 4'b0010, 4'b0000, 4'b0000}, 16'h7BDE, {7'h79, 7'h24, 7'h08, 7'h0E}, 4'b1101};
      tbl[1] = '{'{16'h0123, 4'b1000, 4'b0000, 4'b0000}, 16'h7BDE, {7'h40, 7'h79, 7'h24, 7'h30}, 4'b0111};
      tbl[2] = '{'{16'h4567, 4'b0001, 4'b0000, 4'b0000}, 16'h7BDE, {7'h19, 7'h12, 7'h02, 7'h78}, 4'b1110};
      tbl[3] = '{'{16'h89AB, 4'b0000, 4'b0000, 4'b0000}, 16'h7BDE, {7'h00, 7'h10, 7'h08, 7'h03}, 4'b1111};
      tbl[4] = '{'{16'hCDEF, 4'b0000, 4'b0100, 4'b0000}, 16'h7FDE, {7'h46, 7'h7F, 7'h06, 7'h0E}, 4'b1111};
      m_valid = 0; m_t = 0; m_pend = 0; m_act = '0; m_sh = '0;
      rst = 1; load = 0; digits_in = '0; dp_in = '0; blank_in = '0; blink_in = '0;

      // Reset, then idle: dark display with a frame_done pulse every frame.
      step(0, '0, 1);
      step(0, '0, 0);
      fdc = 0;
      for (int i = 0; i < 2 * FR; i++) begin
         step(0, '0, 0);
         if (obs_fd) fdc++;
      end
      chk("idle_fd_count", fdc, 2);

      for (int i = 0; i < 5; i++) apply_vec(tbl[i]);

      // Second load while pending is ignored; ready returns right after the commit.
      step(1, '{16'h1111, 4'h0, 4'h0, 4'h0}, 0);
      step(0, '0, 0);
      chk("busy_ready_low", ready, 0);
      step(1, '{16'h8888, 4'h0, 4'h0, 4'h0}, 0);
      wait_fd("busy_fd_timeout");
      step(0, '0, 0);
      chk("busy_ready_high", ready, 1);
      for (int i = 0; i < 4; i++) step(0, '0, 0);
      chk("busy_an", an, 4'b0111);
      chk("busy_seg", seg, 7'h79);

      // Blink on digit 0 across several phase flips.
      step(1, '{16'h0000, 4'h0, 4'h0, 4'b0001}, 0);
      for (int i = 0; i < 3 * KC; i++) step(0, '0, 0);

      // Reset mid-slot with a pending load.
      step(1, '{16'h8888, 4'hF, 4'h0, 4'h0}, 0);
      for (int i = 0; i < 3; i++) step(0, '0, 0);
      step(0, '0, 1);
      step(0, '0, 0);
      chk("rst_an", an, 4'hF);
      chk("rst_seg", seg, 7'h7F);
      chk("rst_dp", dp, 1);
      chk("rst_ready", ready, 1);
      chk("rst_fd", frame_done, 0);
      for (int i = 0; i < 2 * FR + 5; i++) step(0, '0, 0);

      // Load accepted on the frame_done cycle waits for the following boundary.
      n = 0;
      while ((m_t % FR) != FR - 1 && n < 2 * FR) begin step(0, '0, 0); n++; end
      step(1, '{16'h4321, 4'h0, 4'h0, 4'h0}, 0);
      step(0, '0, 0);
      chk("edge_ready_low", ready, 0);
      wait_fd("edge_fd_timeout");
      step(0, '0, 0);
      chk("edge_ready_high", ready, 1);
      for (int i = 0; i < FR; i++) step(0, '0, 0);

      // Random traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         rv.dig = 16'($urandom);
         rv.dpv = 4'($urandom);
         rv.bnk = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
         rv.bkl = 4'($urandom);
         step($urandom_range(0, 3) == 0, rv, $urandom_range(0, 999) == 0);
      end
      step(0, '0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
